// File: rtl/divu_seq.sv
// Sequential unsigned divider: drives one restoring-division step per cycle
// for 32 cycles, with valid/ready handshakes on operands and results.

module divu_1iter (
    input  logic [31:0] remainder_in,
    input  logic [31:0] quotient_in,
    input  logic [31:0] dividend_in,
    input  logic [31:0] divisor,
    output logic [31:0] remainder_out,
    output logic [31:0] quotient_out,
    output logic [31:0] dividend_out
);
    logic [32:0] shifted;
    logic        ge;

    // The extra top bit keeps the compare exact even if remainder_in[31] were set.
    assign shifted       = {remainder_in, dividend_in[31]};
    assign ge            = (shifted >= {1'b0, divisor});
    assign remainder_out = ge ? (shifted[31:0] - divisor) : shifted[31:0];
    assign quotient_out  = (quotient_in << 1) | {31'b0, ge};
    assign dividend_out  = dividend_in << 1;
endmodule

module divu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] rem_r, quo_r, div_r, dvs_r;
    logic [WIDTH-1:0] rem_nx, quo_nx, div_nx;
    logic [CNT_W-1:0] cnt;

    divu_1iter u_step (
        .remainder_in  (rem_r),
        .quotient_in   (quo_r),
        .dividend_in   (div_r),
        .divisor       (dvs_r),
        .remainder_out (rem_nx),
        .quotient_out  (quo_nx),
        .dividend_out  (div_nx)
    );

    always_comb begin
        next_state = state;
        in_ready   = (state == IDLE) && !rst;
        out_valid  = (state == DONE);
        busy       = (state == BUSY);
        case (state)
            IDLE: if (in_valid && in_ready)
                      next_state = (divisor != '0) ? BUSY : DONE;
            BUSY: if (cnt == LAST) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem_r <= '0;
            quo_r <= '0;
            div_r <= '0;
            dvs_r <= '0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && in_valid) begin
                div_r <= dividend;
                dvs_r <= divisor;
                cnt   <= '0;
                // Zero divisor follows the RISC-V DIVU/REMU result convention.
                if (divisor != '0) begin
                    rem_r <= '0;
                    quo_r <= '0;
                end else begin
                    rem_r <= dividend;
                    quo_r <= '1;
                end
            end else if (state == BUSY) begin
                rem_r <= rem_nx;
                quo_r <= quo_nx;
                div_r <= div_nx;
                cnt   <= cnt + 1'b1;
            end
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;
endmodule
